// File: rtl/alu_rs_sched_if.sv
// Dispatch, CDB-snoop and ALU-issue bus of the ALU reservation station.
// master = dispatch/CDB/ALU side, slave = alu_rs_sched.
interface alu_rs_sched_if #(
    parameter int unsigned ROB_W = 4,
    parameter int unsigned OP_W  = 6
);
    logic             disp_flag_in;
    logic [OP_W-1:0]  disp_op_in;
    logic [31:0]      disp_val1_in;
    logic [31:0]      disp_val2_in;
    logic             disp_q1_rdy_in;
    logic             disp_q2_rdy_in;
    logic [ROB_W-1:0] disp_q1_in;
    logic [ROB_W-1:0] disp_q2_in;
    logic [ROB_W-1:0] disp_idx_in_ROB_in;
    logic             full_out;

    logic             cdb_flag_in;
    logic [31:0]      cdb_val_in;
    logic [ROB_W-1:0] cdb_idx_in_ROB_in;

    logic             alu_flag_out;
    logic [OP_W-1:0]  alu_op_out;
    logic [31:0]      alu_val1_out;
    logic [31:0]      alu_val2_out;
    logic [ROB_W-1:0] alu_idx_in_ROB_out;

    modport master (
        output disp_flag_in, disp_op_in, disp_val1_in, disp_val2_in,
               disp_q1_rdy_in, disp_q2_rdy_in, disp_q1_in, disp_q2_in,
               disp_idx_in_ROB_in, cdb_flag_in, cdb_val_in, cdb_idx_in_ROB_in,
        input  full_out, alu_flag_out, alu_op_out, alu_val1_out, alu_val2_out,
               alu_idx_in_ROB_out
    );

    modport slave (
        input  disp_flag_in, disp_op_in, disp_val1_in, disp_val2_in,
               disp_q1_rdy_in, disp_q2_rdy_in, disp_q1_in, disp_q2_in,
               disp_idx_in_ROB_in, cdb_flag_in, cdb_val_in, cdb_idx_in_ROB_in,
        output full_out, alu_flag_out, alu_op_out, alu_val1_out, alu_val2_out,
               alu_idx_in_ROB_out
    );
endinterface

// File: rtl/alu_rs_sched.sv
// Reservation station for the integer ALU: buffers micro-ops, wakes them from the CDB, issues one per cycle.
// Optional RS_AGE_SELECT_EN: oldest-ready selection using per-entry saturating ages.
module alu_rs_sched #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned OP_W    = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic           clear_in,
    alu_rs_sched_if.slave  bus
);
    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy, r1, r2, ready;
    logic [OP_W-1:0]    op   [RS_SIZE];
    logic [31:0]        val1 [RS_SIZE];
    logic [31:0]        val2 [RS_SIZE];
    logic [ROB_W-1:0]   q1   [RS_SIZE];
    logic [ROB_W-1:0]   q2   [RS_SIZE];
    logic [ROB_W-1:0]   dest [RS_SIZE];

    logic             sel_vld, free_vld, full, disp_acc, fwd1, fwd2;
    logic [IDX_W-1:0] sel_idx, free_idx;

`ifdef RS_AGE_SELECT_EN
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(RS_SIZE - 1);
    logic [IDX_W-1:0] age [RS_SIZE];
    logic [IDX_W-1:0] best_age;
`endif

    assign ready        = busy & r1 & r2;
    assign full         = &busy;
    assign bus.full_out = full;

    // Issue select: oldest ready with ages, else lowest-index ready; ties to lower index.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
`ifdef RS_AGE_SELECT_EN
        best_age = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!sel_vld || age[i] > best_age)) begin
                sel_vld  = 1'b1;
                sel_idx  = IDX_W'(i);
                best_age = age[i];
            end
        end
`else
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && !sel_vld) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
`endif
    end

    // Lowest free slot for dispatch, plus same-cycle CDB forwarding into the new entry.
    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!busy[i] && !free_vld) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        disp_acc = bus.disp_flag_in && free_vld;
        fwd1 = !bus.disp_q1_rdy_in && bus.cdb_flag_in && (bus.disp_q1_in == bus.cdb_idx_in_ROB_in);
        fwd2 = !bus.disp_q2_rdy_in && bus.cdb_flag_in && (bus.disp_q2_in == bus.cdb_idx_in_ROB_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy                   <= '0;
            r1                     <= '0;
            r2                     <= '0;
            bus.alu_flag_out       <= 1'b0;
            bus.alu_op_out         <= '0;
            bus.alu_val1_out       <= '0;
            bus.alu_val2_out       <= '0;
            bus.alu_idx_in_ROB_out <= '0;
`ifdef RS_AGE_SELECT_EN
            for (int unsigned i = 0; i < RS_SIZE; i++) age[i] <= '0;
`endif
        end else if (clear_in) begin
            busy             <= '0;
            bus.alu_flag_out <= 1'b0;
`ifdef RS_AGE_SELECT_EN
            for (int unsigned i = 0; i < RS_SIZE; i++) age[i] <= '0;
`endif
        end else if (!rdy) begin
            bus.alu_flag_out <= 1'b0;
        end else begin
            bus.alu_flag_out <= sel_vld;
            if (sel_vld) begin
                bus.alu_op_out         <= op[sel_idx];
                bus.alu_val1_out       <= val1[sel_idx];
                bus.alu_val2_out       <= val2[sel_idx];
                bus.alu_idx_in_ROB_out <= dest[sel_idx];
                busy[sel_idx]          <= 1'b0;
            end
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && bus.cdb_flag_in) begin
                    if (!r1[i] && q1[i] == bus.cdb_idx_in_ROB_in) begin
                        val1[i] <= bus.cdb_val_in;
                        r1[i]   <= 1'b1;
                    end
                    if (!r2[i] && q2[i] == bus.cdb_idx_in_ROB_in) begin
                        val2[i] <= bus.cdb_val_in;
                        r2[i]   <= 1'b1;
                    end
                end
`ifdef RS_AGE_SELECT_EN
                if (disp_acc && busy[i] && age[i] != AGE_MAX) age[i] <= age[i] + IDX_W'(1);
`endif
            end
            if (disp_acc) begin
                busy[free_idx] <= 1'b1;
                op[free_idx]   <= bus.disp_op_in;
                val1[free_idx] <= fwd1 ? bus.cdb_val_in : bus.disp_val1_in;
                val2[free_idx] <= fwd2 ? bus.cdb_val_in : bus.disp_val2_in;
                r1[free_idx]   <= bus.disp_q1_rdy_in | fwd1;
                r2[free_idx]   <= bus.disp_q2_rdy_in | fwd2;
                q1[free_idx]   <= bus.disp_q1_in;
                q2[free_idx]   <= bus.disp_q2_in;
                dest[free_idx] <= bus.disp_idx_in_ROB_in;
`ifdef RS_AGE_SELECT_EN
                age[free_idx]  <= '0;
`endif
            end
        end
    end
endmodule

// File: doc/alu_rs_sched.md
Name: alu_rs_sched

Overview:
- Reservation-station scheduler in front of the integer ALU.
- Buffers dispatched ALU/branch/JALR micro-ops until both operands are available, and snoops the CDB to wake them up.
- Issues at most one ready entry per cycle to the ALU.
- Sits between the decoder/dispatch stage and the ALU; the ALU's CDB output is snooped back by this block.

Parameters:
- RS_SIZE, 8, number of entries (power of two, 2..16).
- ROB_W, 4, width of a ROB index / operand tag.
- OP_W, 6, width of the ALU opcode field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; 0 = stall
- clear_in  in  1  pipeline flush (branch mispredict)
- disp_flag_in  in  1  dispatch valid
- disp_op_in  in  OP_W  ALU opcode
- disp_val1_in / disp_val2_in  in  32 each  operand values
- disp_q1_rdy_in / disp_q2_rdy_in  in  1 each  1 = operand value already valid
- disp_q1_in / disp_q2_in  in  ROB_W each  producer ROB tag when not ready
- disp_idx_in_ROB_in  in  ROB_W  destination ROB index
- full_out  out  1  no free entry
- cdb_flag_in  in  1  CDB broadcast valid
- cdb_val_in  in  32  broadcast value
- cdb_idx_in_ROB_in  in  ROB_W  broadcast tag
- alu_flag_out  out  1  issue valid to ALU
- alu_op_out  out  OP_W  opcode
- alu_val1_out / alu_val2_out  out  32 each  operands
- alu_idx_in_ROB_out  out  ROB_W  ROB index

Behaviour:
- Reset (rst=1 at posedge):
  - all entries invalid;
  - alu_flag_out=0, alu_op_out=0, alu_val1_out=0, alu_val2_out=0, alu_idx_in_ROB_out=0;
  - full_out=0.
- Entry fields: busy, op, val1, val2, q1, q2, r1, r2, dest, plus age when the optional feature is on.
- Priority per edge: rst > clear_in > rdy=0 > normal operation.
- clear_in=1 (with rdy=1):
  - all entries invalidated;
  - alu_flag_out=0;
  - same-cycle dispatch and CDB ignored.
- rdy=0:
  - entry state held;
  - alu_flag_out registered 0 (no duplicate issue);
  - dispatch and CDB inputs ignored.
- Dispatch:
  - When disp_flag_in=1 and full_out=0, write the lowest-index free entry.
  - Dispatch while full_out=1 is dropped; the dispatcher must not do this.
- Dispatch-time forwarding: if cdb_flag_in=1 and cdb_idx_in_ROB_in equals a not-ready disp_qN_in in the same cycle, capture cdb_val_in and mark that operand ready.
- Wakeup:
  - Every busy entry with rN=0 and qN==cdb_idx_in_ROB_in (cdb_flag_in=1) latches cdb_val_in and sets rN=1.
  - Both operands may wake in the same cycle.
- Ready condition: busy and r1 and r2, evaluated on registered state. An entry woken at edge N is first selectable in the cycle after edge N.
- Select: lowest-index ready entry; one issue per cycle.
- Issue:
  - At the edge, the selected entry's fields are registered onto the alu_* outputs, alu_flag_out=1, and the entry is freed.
  - With no ready entry, alu_flag_out=0 and the other alu_* outputs hold their value.
  - Latency: dispatch with both operands ready at edge N → alu_flag_out=1 after edge N+1.
- A freed slot may be re-dispatched at the next edge. A slot cannot be freed and refilled at the same edge.
- full_out is combinational from the registered busy vector: 1 iff all RS_SIZE entries are busy.
- Tag equality compares the full ROB_W bits. No wrap handling is needed because the ROB guarantees unique live tags.

Optional Feature:
- Macro RS_AGE_SELECT_EN.
- Defined:
  - Each entry carries a ceil(log2(RS_SIZE))-bit age.
  - On dispatch the new entry gets age 0 and every busy entry's age is incremented; ages saturate at RS_SIZE-1.
  - Select picks the ready entry with the largest age; ties go to the lower index.
  - Ages are cleared by rst and clear_in.
- Undefined: lowest-index-ready selection, and no age storage is synthesized.

Test Plan:
- Reset, then dispatch ADD val1=5 val2=7 both ready, dest=3 → after edge N+1: alu_flag_out=1, alu_op_out=`ADD, vals 5/7, alu_idx_in_ROB_out=3. Next cycle alu_flag_out=0.
- Dispatch SUB with q1=tag 2 not ready, val2=1. Two cycles later CDB tag=2 val=10 → one cycle after the broadcast, issue with val1=10 val2=1. No issue before the broadcast.
- Same-cycle forward: dispatch with q2=tag 6 while CDB broadcasts tag 6 val=0xFFFF_FFFF → entry issues with val2=0xFFFF_FFFF and no further wait.
- Fill all 8 entries with unready ops → full_out=1, and a 9th dispatch is dropped. Broadcast the tag that wakes entry 4 → entry 4 issues, and full_out=0 one edge later.
- Three entries ready, then clear_in=1 → no issue on any later cycle and full_out=0. Pulse rdy=0 for 3 cycles with a ready entry → alu_flag_out=0 during the stall, then the entry issues once after rdy returns.
- With RS_AGE_SELECT_EN: dispatch A into slot 0, B into slot 1 with A not ready. Free slot 0, refill it with C. Make B and C ready together → B issues before C.
